// File: rtl/debug_pkg.sv
// +--------------------------------------------------------------------------+
// | debug_pkg: opcodes, FSM state encoding and frame constants shared by the |
// | debug command controller and its frame serializer.                       |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
`default_nettype none

package debug_pkg;

    localparam logic [7:0]  c_OP_SIGNAL  = 8'h01;
    localparam logic [7:0]  c_OP_OK      = 8'h02;
    localparam logic [7:0]  c_OP_PING    = 8'h03;
    localparam logic [7:0]  c_OP_PAUSE   = 8'h04;
    localparam logic [7:0]  c_OP_RESUME  = 8'h05;
    localparam logic [7:0]  c_OP_NEXT    = 8'h06;
    localparam logic [7:0]  c_OP_PROGRAM = 8'h07;

    localparam int          c_SIGNAL_LEN = 5;
    localparam logic [31:0] c_BP_NONE    = 32'hFFFF_FFFF;

    typedef enum logic [2:0] {
        S_IDLE      = 3'd0,
        S_ARG       = 3'd1,
        S_PROG      = 3'd2,
        S_STEP_WAIT = 3'd3,
        S_TX        = 3'd4
    } state_t;

    typedef enum logic {
        ARG_RESUME = 1'b0,
        ARG_COUNT  = 1'b1
    } arg_kind_t;

endpackage

`default_nettype wire

// File: rtl/debug_frame_tx.sv
// +--------------------------------------------------------------------------+
// | debug_frame_tx: loads a 1-byte reply or an opcode + 32-bit LE word and   |
// | serializes it over a valid/ready byte interface.                         |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
`default_nettype none

module debug_frame_tx
    import debug_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        i_load,
    input  logic        i_long,
    input  logic [7:0]  i_opcode,
    input  logic [31:0] i_word,
    output logic [7:0]  o_tx_data,
    output logic        o_tx_valid,
    input  logic        i_tx_ready,
    output logic        o_last
);

    logic [39:0] r_shift;
    logic [2:0]  r_left;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_shift <= '0;
            r_left  <= '0;
        end else if (i_load) begin
            r_shift <= {i_word, i_opcode};
            r_left  <= i_long ? 3'(c_SIGNAL_LEN) : 3'd1;
        end else if (o_tx_valid && i_tx_ready) begin
            r_shift <= {8'h00, r_shift[39:8]};
            r_left  <= r_left - 3'd1;
        end
    end

    // Data comes straight from the shift register, so it is stable while stalled.
    assign o_tx_valid = (r_left != 3'd0);
    assign o_tx_data  = r_shift[7:0];
    assign o_last     = o_tx_valid && i_tx_ready && (r_left == 3'd1);

endmodule

`default_nettype wire

// File: rtl/debug_cmd_ctrl.sv
// +--------------------------------------------------------------------------+
// | debug_cmd_ctrl: host command sequencer driving CPU pause/step,           |
// | breakpoint and IMEM reprogramming; replies with OK / SIGNAL frames.      |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
`default_nettype none

module debug_cmd_ctrl
    import debug_pkg::*;
#(
    parameter int IMEM_WORDS  = 256,
    parameter int ADDR_W      = 8,
    parameter int TIMEOUT_CYC = 100000
)(
    input  logic              clk,
    input  logic              rst_n,
    input  logic [7:0]        rx_data,
    input  logic              rx_valid,
    output logic [7:0]        tx_data,
    output logic              tx_valid,
    input  logic              tx_ready,
    input  logic              commit_valid,
    input  logic [31:0]       commit_pc,
    output logic              cpu_pause,
    output logic              cpu_step,
    output logic              cpu_rst_req,
    output logic              prog_we,
    output logic [ADDR_W-1:0] prog_addr,
    output logic [31:0]       prog_data,
    output logic              busy,
    output logic              overrun
);

    localparam int c_CNT_W   = $clog2(TIMEOUT_CYC + 2);
    localparam int c_WORDS_W = $clog2(IMEM_WORDS + 1);

    state_t               r_state;
    arg_kind_t            r_kind;
    logic                 r_pause, r_step, r_rst_req, r_we;
    logic [ADDR_W-1:0]    r_addr, r_wr_idx;
    logic [31:0]          r_data, r_bp, r_last_pc;
    logic [23:0]          r_arg;
    logic [1:0]           r_byte_cnt;
    logic [c_CNT_W-1:0]   r_cnt;
    logic [c_WORDS_W-1:0] r_words_left;
    logic                 r_report_pend, r_hold_vld, r_overrun;
    logic [7:0]           r_hold_byte;
    logic                 r_tx_load, r_tx_long;
    logic [7:0]           r_tx_op;
    logic [31:0]          r_tx_word;

    logic                 w_accept, w_in_vld, w_bp_hit, w_gap_over, w_step_to, w_tx_last;
    logic [7:0]           w_in_byte;
    logic [31:0]          w_word, w_last_pc_nxt;
    logic [c_WORDS_W-1:0] w_n_sat;

    // Byte stream is consumed only in states that parse input; a finished
    // PROGRAM waiting to reply leaves new bytes for the hold register.
    assign w_accept      = (r_state == S_IDLE) || (r_state == S_ARG) ||
                           ((r_state == S_PROG) && (r_words_left != '0));
    assign w_in_vld      = w_accept && (r_hold_vld || rx_valid);
    assign w_in_byte     = r_hold_vld ? r_hold_byte : rx_data;
    assign w_word        = {w_in_byte, r_arg};
    assign w_last_pc_nxt = commit_valid ? commit_pc : r_last_pc;
    assign w_bp_hit      = !r_pause && commit_valid && (commit_pc == r_bp) && (r_bp != c_BP_NONE);
    assign w_gap_over    = (r_cnt == c_CNT_W'(TIMEOUT_CYC));
    assign w_step_to     = (r_cnt == c_CNT_W'(TIMEOUT_CYC - 1));
    assign w_n_sat       = (w_word > 32'(IMEM_WORDS)) ? c_WORDS_W'(IMEM_WORDS)
                                                      : w_word[c_WORDS_W-1:0];

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state       <= S_IDLE;
            r_kind        <= ARG_RESUME;
            r_pause       <= 1'b1;
            r_step        <= 1'b0;
            r_rst_req     <= 1'b0;
            r_we          <= 1'b0;
            r_addr        <= '0;
            r_wr_idx      <= '0;
            r_data        <= '0;
            r_bp          <= c_BP_NONE;
            r_last_pc     <= '0;
            r_arg         <= '0;
            r_byte_cnt    <= '0;
            r_cnt         <= '0;
            r_words_left  <= '0;
            r_report_pend <= 1'b0;
            r_hold_vld    <= 1'b0;
            r_hold_byte   <= '0;
            r_overrun     <= 1'b0;
            r_tx_load     <= 1'b0;
            r_tx_long     <= 1'b0;
            r_tx_op       <= '0;
            r_tx_word     <= '0;
        end else begin
            r_step    <= 1'b0;
            r_we      <= 1'b0;
            r_rst_req <= 1'b0;
            r_tx_load <= 1'b0;

            if (commit_valid)
                r_last_pc <= commit_pc;

            // Hold register: the held byte always goes first into the parser.
            if (rx_valid) begin
                if (w_accept) begin
                    if (r_hold_vld)
                        r_hold_byte <= rx_data;
                end else if (!r_hold_vld) begin
                    r_hold_vld  <= 1'b1;
                    r_hold_byte <= rx_data;
                end else begin
                    r_overrun <= 1'b1;
                end
            end else if (w_accept && r_hold_vld) begin
                r_hold_vld <= 1'b0;
            end

            case (r_state)
                S_IDLE: begin
                    if (w_in_vld) begin
                        case (w_in_byte)
                            c_OP_PING: begin
                                r_tx_load <= 1'b1;
                                r_tx_long <= 1'b0;
                                r_tx_op   <= c_OP_OK;
                                r_state   <= S_TX;
                            end
                            c_OP_PAUSE: begin
                                r_pause   <= 1'b1;
                                r_tx_load <= 1'b1;
                                r_tx_long <= 1'b1;
                                r_tx_op   <= c_OP_SIGNAL;
                                r_tx_word <= w_last_pc_nxt;
                                r_state   <= S_TX;
                            end
                            c_OP_RESUME: begin
                                r_kind     <= ARG_RESUME;
                                r_byte_cnt <= '0;
                                r_cnt      <= '0;
                                r_state    <= S_ARG;
                            end
                            c_OP_NEXT: begin
                                if (r_pause) begin
                                    r_step  <= 1'b1;
                                    r_cnt   <= '0;
                                    r_state <= S_STEP_WAIT;
                                end
                            end
                            c_OP_PROGRAM: begin
                                r_pause    <= 1'b1;
                                r_kind     <= ARG_COUNT;
                                r_byte_cnt <= '0;
                                r_cnt      <= '0;
                                r_state    <= S_ARG;
                            end
                            default: ;
                        endcase
                    end else if (r_report_pend) begin
                        r_report_pend <= 1'b0;
                        r_tx_load     <= 1'b1;
                        r_tx_long     <= 1'b1;
                        r_tx_op       <= c_OP_SIGNAL;
                        r_tx_word     <= w_last_pc_nxt;
                        r_state       <= S_TX;
                    end
                end
                S_ARG: begin
                    if (w_in_vld) begin
                        r_arg      <= w_word[31:8];
                        r_byte_cnt <= r_byte_cnt + 2'd1;
                        r_cnt      <= '0;
                        if (r_byte_cnt == 2'd3) begin
                            if (r_kind == ARG_RESUME) begin
                                r_bp    <= w_word;
                                r_pause <= 1'b0;
                                r_state <= S_IDLE;
                            end else begin
                                r_words_left <= w_n_sat;
                                r_wr_idx     <= '0;
                                r_state      <= S_PROG;
                            end
                        end
                    end else if (w_gap_over) begin
                        r_state <= S_IDLE;
                    end else begin
                        r_cnt <= r_cnt + c_CNT_W'(1);
                    end
                end
                S_PROG: begin
                    if (r_words_left == '0) begin
                        r_rst_req <= 1'b1;
                        r_tx_load <= 1'b1;
                        r_tx_long <= 1'b0;
                        r_tx_op   <= c_OP_OK;
                        r_state   <= S_TX;
                    end else if (w_in_vld) begin
                        r_arg      <= w_word[31:8];
                        r_byte_cnt <= r_byte_cnt + 2'd1;
                        r_cnt      <= '0;
                        if (r_byte_cnt == 2'd3) begin
                            r_we         <= 1'b1;
                            r_addr       <= r_wr_idx;
                            r_data       <= w_word;
                            r_wr_idx     <= r_wr_idx + ADDR_W'(1);
                            r_words_left <= r_words_left - c_WORDS_W'(1);
                        end
                    end else if (w_gap_over) begin
                        r_state <= S_IDLE;
                    end else begin
                        r_cnt <= r_cnt + c_CNT_W'(1);
                    end
                end
                S_STEP_WAIT: begin
                    if (commit_valid || w_step_to) begin
                        r_tx_load <= 1'b1;
                        r_tx_long <= 1'b1;
                        r_tx_op   <= c_OP_SIGNAL;
                        r_tx_word <= w_last_pc_nxt;
                        r_state   <= S_TX;
                    end else begin
                        r_cnt <= r_cnt + c_CNT_W'(1);
                    end
                end
                S_TX: begin
                    if (w_tx_last)
                        r_state <= S_IDLE;
                end
                default: r_state <= S_IDLE;
            endcase

            // Breakpoint runs beside the FSM; the report waits for the next idle slot.
            if (w_bp_hit) begin
                r_pause       <= 1'b1;
                r_report_pend <= 1'b1;
            end
        end
    end

    debug_frame_tx u_frame_tx (
        .clk        (clk),
        .rst_n      (rst_n),
        .i_load     (r_tx_load),
        .i_long     (r_tx_long),
        .i_opcode   (r_tx_op),
        .i_word     (r_tx_word),
        .o_tx_data  (tx_data),
        .o_tx_valid (tx_valid),
        .i_tx_ready (tx_ready),
        .o_last     (w_tx_last)
    );

    assign cpu_pause   = r_pause;
    assign cpu_step    = r_step;
    assign cpu_rst_req = r_rst_req;
    assign prog_we     = r_we;
    assign prog_addr   = r_addr;
    assign prog_data   = r_data;
    assign busy        = (r_state != S_IDLE);
    assign overrun     = r_overrun;

endmodule

`default_nettype wire

// File: tb/tb_debug_cmd_ctrl.sv
// +--------------------------------------------------------------------------+
// | tb_debug_cmd_ctrl: self-checking bench for debug_cmd_ctrl.               |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
`default_nettype none

module tb_debug_cmd_ctrl;

    localparam int IMEM = 4;
    localparam int AW   = 3;
    localparam int TO   = 40;

    logic          clk = 1'b0;
    logic          rst_n;
    logic [7:0]    rx_data;
    logic          rx_valid;
    logic [7:0]    tx_data;
    logic          tx_valid;
    logic          tx_ready;
    logic          commit_valid;
    logic [31:0]   commit_pc;
    logic          cpu_pause, cpu_step, cpu_rst_req, prog_we, busy, overrun;
    logic [AW-1:0] prog_addr;
    logic [31:0]   prog_data;

    always #5 clk = ~clk;

    debug_cmd_ctrl #(.IMEM_WORDS(IMEM), .ADDR_W(AW), .TIMEOUT_CYC(TO)) dut (
        .clk(clk), .rst_n(rst_n), .rx_data(rx_data), .rx_valid(rx_valid),
        .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
        .commit_valid(commit_valid), .commit_pc(commit_pc),
        .cpu_pause(cpu_pause), .cpu_step(cpu_step), .cpu_rst_req(cpu_rst_req),
        .prog_we(prog_we), .prog_addr(prog_addr), .prog_data(prog_data),
        .busy(busy), .overrun(overrun)
    );

    logic [7:0]    got_tx[$], exp_tx[$];
    logic [AW-1:0] got_addr[$], exp_addr[$];
    logic [31:0]   got_data[$], exp_data[$];
    int            n_step = 0, n_rst = 0;
    int            n_chk = 0, n_err = 0;
    logic          rand_rdy = 1'b0;
    logic [31:0]   model_pc = 32'h0;

    always @(negedge clk) begin
        if (rst_n) begin
            if (tx_valid && tx_ready) got_tx.push_back(tx_data);
            if (prog_we) begin
                got_addr.push_back(prog_addr);
                got_data.push_back(prog_data);
            end
            if (cpu_step)    n_step++;
            if (cpu_rst_req) n_rst++;
        end
    end

    typedef struct {
        logic [7:0] op;
        int         len;
        logic [7:0] first;
        logic       pause;
        int         steps;
    } vec_t;
    vec_t tbl[8];

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, got, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
        if (rand_rdy) tx_ready = ($urandom % 3) != 0;
    endtask

    task automatic send_byte(input logic [7:0] b);
        rx_data  = b;
        rx_valid = 1'b1;
        cyc();
        rx_valid = 1'b0;
    endtask

    task automatic send_gap(input logic [7:0] b);
        send_byte(b);
        repeat ($urandom_range(0, 3)) cyc();
    endtask

    task automatic send_word(input logic [31:0] w);
        for (int i = 0; i < 4; i++) send_gap(w[8*i +: 8]);
    endtask

    task automatic commit(input logic [31:0] pc);
        commit_valid = 1'b1;
        commit_pc    = pc;
        model_pc     = pc;
        cyc();
        commit_valid = 1'b0;
    endtask

    task automatic wait_idle(input string name);
        int k;
        k = 0;
        repeat (3) cyc();
        while ((busy || tx_valid) && k < 4 * TO + 100) begin
            cyc();
            k++;
        end
        if (busy || tx_valid) begin
            n_chk++;
            n_err++;
            $display("FAIL %s: still active after budget busy=%0b tx_valid=%0b", name, busy, tx_valid);
        end
    endtask

    function automatic void exp_sig(input logic [31:0] pc);
        exp_tx.push_back(8'h01);
        for (int i = 0; i < 4; i++) exp_tx.push_back(pc[8*i +: 8]);
    endfunction

    task automatic check_tx(input string name);
        check({name, "_len"}, got_tx.size(), exp_tx.size());
        for (int i = 0; i < exp_tx.size() && i < got_tx.size(); i++)
            check($sformatf("%s_b%0d", name, i), got_tx[i], exp_tx[i]);
        got_tx.delete();
        exp_tx.delete();
    endtask

    task automatic check_wr(input string name);
        check({name, "_nwr"}, got_addr.size(), exp_addr.size());
        for (int i = 0; i < exp_addr.size() && i < got_addr.size(); i++) begin
            check($sformatf("%s_a%0d", name, i), got_addr[i], exp_addr[i]);
            check($sformatf("%s_d%0d", name, i), got_data[i], exp_data[i]);
        end
        got_addr.delete(); got_data.delete();
        exp_addr.delete(); exp_data.delete();
    endtask

    initial begin
        #3_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int s0, r0, n, kind;
        logic [31:0] w, bp;

        tbl[0] = '{8'h03, 1, 8'h02, 1'b1, 0};
        tbl[1] = '{8'h04, 5, 8'h01, 1'b1, 0};
        tbl[2] = '{8'h00, 0, 8'h00, 1'b1, 0};
        tbl[3] = '{8'h08, 0, 8'h00, 1'b1, 0};
        tbl[4] = '{8'hFF, 0, 8'h00, 1'b1, 0};
        tbl[5] = '{8'h06, 5, 8'h01, 1'b1, 1};
        tbl[6] = '{8'h01, 0, 8'h00, 1'b1, 0};
        tbl[7] = '{8'h02, 0, 8'h00, 1'b1, 0};

        rst_n = 1'b0; rx_valid = 1'b0; rx_data = 8'h00; tx_ready = 1'b1;
        commit_valid = 1'b0; commit_pc = 32'h0;
        repeat (3) cyc();
        rst_n = 1'b1;
        cyc();

        check("rst_pause", cpu_pause, 1);
        check("rst_step", cpu_step, 0);
        check("rst_rstreq", cpu_rst_req, 0);
        check("rst_we", prog_we, 0);
        check("rst_txv", tx_valid, 0);
        check("rst_busy", busy, 0);
        check("rst_ovr", overrun, 0);

        // PING after reset
        send_byte(8'h03);
        wait_idle("ping");
        exp_tx.push_back(8'h02);
        check_tx("ping");
        check("ping_pause", cpu_pause, 1);

        foreach (tbl[i]) begin
            s0 = n_step;
            send_byte(tbl[i].op);
            wait_idle("tbl");
            check($sformatf("tbl%0d_len", i), got_tx.size(), tbl[i].len);
            if (got_tx.size() > 0) check($sformatf("tbl%0d_first", i), got_tx[0], tbl[i].first);
            check($sformatf("tbl%0d_pause", i), cpu_pause, tbl[i].pause);
            check($sformatf("tbl%0d_steps", i), n_step - s0, tbl[i].steps);
            got_tx.delete();
        end

        // RESUME with breakpoint at 4
        send_byte(8'h05); send_word(32'h0000_0004);
        check("resume_run", cpu_pause, 0);
        commit(32'h0);
        check("bp_pc0_run", cpu_pause, 0);
        commit(32'h4);
        check("bp_hit_pause", cpu_pause, 1);
        wait_idle("bp");
        exp_sig(32'h4);
        check_tx("bp_sig");

        // NEXT while paused
        send_byte(8'h06);
        check("step_pulse", cpu_step, 1);
        cyc();
        check("step_pulse_end", cpu_step, 0);
        commit(32'h8);
        wait_idle("next");
        exp_sig(32'h8);
        check_tx("next_sig");

        // NEXT while running is ignored
        send_byte(8'h05); send_word(32'hFFFF_FFFF);
        check("run_nobp", cpu_pause, 0);
        s0 = n_step;
        send_byte(8'h06);
        repeat (10) cyc();
        check("next_run_steps", n_step - s0, 0);
        check("next_run_tx", got_tx.size(), 0);
        check("next_run_busy", busy, 0);
        send_byte(8'h04);
        wait_idle("pause");
        exp_sig(model_pc);
        check_tx("pause_sig");
        check("pause_pause", cpu_pause, 1);

        // PROGRAM two words
        r0 = n_rst;
        send_byte(8'h07); send_word(32'd2);
        send_word(32'h1234_5678); send_word(32'hDEAD_BEEF);
        wait_idle("prog");
        exp_addr.push_back(AW'(0)); exp_data.push_back(32'h1234_5678);
        exp_addr.push_back(AW'(1)); exp_data.push_back(32'hDEAD_BEEF);
        check_wr("prog");
        check("prog_rstreq", n_rst - r0, 1);
        exp_tx.push_back(8'h02);
        check_tx("prog_ok");
        check("prog_pause", cpu_pause, 1);

        // PROGRAM count saturates at IMEM depth
        r0 = n_rst;
        send_byte(8'h07); send_word(32'd6);
        for (int i = 0; i < IMEM; i++) begin
            w = $urandom;
            exp_addr.push_back(AW'(i)); exp_data.push_back(w);
            send_word(w);
        end
        wait_idle("psat");
        check_wr("psat");
        check("psat_rstreq", n_rst - r0, 1);
        exp_tx.push_back(8'h02);
        check_tx("psat_ok");

        // Argument timeout
        send_byte(8'h05); send_byte(8'h10); send_byte(8'h00);
        repeat (TO + 3) cyc();
        check("to_busy", busy, 0);
        check("to_pause", cpu_pause, 1);
        check("to_tx", got_tx.size(), 0);
        send_byte(8'h03);
        wait_idle("to_ping");
        exp_tx.push_back(8'h02);
        check_tx("to_ping");

        // Stalled transmitter: hold one byte, drop the next
        tx_ready = 1'b0;
        send_byte(8'h04);
        repeat (2) cyc();
        send_byte(8'h03);
        send_byte(8'h04);
        check("ovr_set", overrun, 1);
        repeat (5) cyc();
        tx_ready = 1'b1;
        wait_idle("hold1");
        wait_idle("hold2");
        exp_sig(model_pc);
        exp_tx.push_back(8'h02);
        check_tx("hold");

        // Reset in the middle of PROGRAM
        send_byte(8'h07); send_word(32'd2); send_byte(8'h78);
        r0 = n_rst;
        rst_n = 1'b0;
        cyc();
        check("mrst_pause", cpu_pause, 1);
        check("mrst_busy", busy, 0);
        check("mrst_we", prog_we, 0);
        check("mrst_ovr", overrun, 0);
        check("mrst_txv", tx_valid, 0);
        rst_n = 1'b1;
        model_pc = 32'h0;
        repeat (5) cyc();
        check("mrst_norst", n_rst - r0, 0);
        check("mrst_nowr", got_addr.size(), 0);
        send_byte(8'h04);
        wait_idle("mrst_pause");
        exp_sig(32'h0);
        check_tx("mrst_sig");

        // Randomized command mix against the transaction-level model
        rand_rdy = 1'b1;
        for (int it = 0; it < 24; it++) begin
            kind = $urandom_range(0, 3);
            r0 = n_rst;
            case (kind)
                0: begin
                    send_gap(8'h03);
                    exp_tx.push_back(8'h02);
                end
                1: begin
                    n = $urandom_range(0, IMEM);
                    send_gap(8'h07); send_word(32'(n));
                    for (int i = 0; i < n; i++) begin
                        w = $urandom;
                        exp_addr.push_back(AW'(i)); exp_data.push_back(w);
                        send_word(w);
                    end
                    exp_tx.push_back(8'h02);
                end
                2: begin
                    bp = {20'h0, 10'($urandom_range(1, 1000)), 2'b00};
                    send_gap(8'h05); send_word(bp);
                    n = $urandom_range(0, 4);
                    for (int j = 0; j < n; j++) begin
                        commit(bp + 32'(4 * (j + 1)));
                        repeat ($urandom_range(0, 2)) cyc();
                    end
                    commit(bp);
                    exp_sig(bp);
                end
                default: begin
                    w = $urandom;
                    send_byte(8'h06);
                    repeat ($urandom_range(0, 3)) cyc();
                    commit(w);
                    exp_sig(w);
                end
            endcase
            wait_idle("rnd");
            check_tx($sformatf("rnd%0d_k%0d", it, kind));
            check($sformatf("rnd%0d_pause", it), cpu_pause, 1);
            if (kind == 1) begin
                check_wr($sformatf("rnd%0d", it));
                check($sformatf("rnd%0d_rstreq", it), n_rst - r0, 1);
            end
        end
        check("end_ovr", overrun, 0);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule

`default_nettype wire
